// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles from the accepting edge of a pixel to its result_valid.
    localparam int PIPE_LAT = 4;

    // Default kernel loaded at reset, index = row*3+col.
    localparam int SOBEL_X [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    // Clamp a signed value into the range of an out_w-bit signed number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/conv_window_gen.sv
// Raster-order window generator: two line buffers feed a 3x3 sliding window.
// win_valid pulses for one cycle after each accepted pixel whose window
// (bottom-right at that pixel) lies fully inside the image.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [PIX_W-1:0]   pixel,
    output logic [9*PIX_W-1:0] window,
    output logic               win_valid,
    output logic               last_pix
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [XW-1:0]    cnt_x;
    logic [YW-1:0]    cnt_y;
    logic [PIX_W-1:0] lb0 [IMG_W];   // row y-1
    logic [PIX_W-1:0] lb1 [IMG_W];   // row y-2
    logic [PIX_W-1:0] win [9];       // index row*3+col, row 0 = oldest line

    assign last_pix = (cnt_x == XW'(IMG_W - 1)) && (cnt_y == YW'(IMG_H - 1));

    // Flatten the window for the MAC tree.
    always_comb begin
        window = '0;
        for (int i = 0; i < 9; i++)
            window[i*PIX_W +: PIX_W] = win[i];
    end

    // Raster position counters; cleared when a frame starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (clear) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (accept) begin
            if (cnt_x == XW'(IMG_W - 1)) begin
                cnt_x <= '0;
                cnt_y <= (cnt_y == YW'(IMG_H - 1)) ? '0 : cnt_y + 1'b1;
            end else begin
                cnt_x <= cnt_x + 1'b1;
            end
        end
    end

    // Line buffers and window shift; everything holds while no pixel is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int i = 0; i < 9; i++)
                win[i] <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= accept && (cnt_x >= XW'(2)) && (cnt_y >= YW'(2));
            if (accept) begin
                lb1[cnt_x] <= lb0[cnt_x];
                lb0[cnt_x] <= pixel;
                for (int r = 0; r < 3; r++) begin
                    win[r*3]     <= win[r*3+1];
                    win[r*3+1]   <= win[r*3+2];
                end
                win[2] <= lb1[cnt_x];
                win[5] <= lb0[cnt_x];
                win[8] <= pixel;
            end
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid convolution with loadable kernel and shift/ReLU/saturate.
// Stream semantics: pixel_in is consumed on every clock edge where
// pixel_valid=1 and the engine is in RUN; there is no back-pressure, and
// result_out is meaningful only on cycles where result_valid=1.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic [PIX_W-1:0]         pixel_in,
    input  logic                     pixel_valid,
    output logic signed [OUT_W-1:0]  result_out,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     done_signal
);

    localparam int ACC_W  = PIX_W + COEF_W + 5;
    localparam int PROD_W = PIX_W + COEF_W + 1;

    state_t                    state;
    logic [2:0]                drain_cnt;
    logic [4:0]                shift_q;
    logic                      relu_q;
    logic signed [COEF_W-1:0]  coef [9];

    logic                      accept;
    logic                      start_ok;
    logic                      last_pix;
    logic                      win_valid;
    logic [9*PIX_W-1:0]        window;

    logic signed [PROD_W-1:0]  prod [9];
    logic signed [ACC_W-1:0]   row_sum [3];
    logic signed [ACC_W-1:0]   total;
    logic                      v1, v2, v3;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   relu_val;

    assign accept   = pixel_valid && (state == RUN);
    assign start_ok = start_signal && (state == IDLE);

    conv_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .accept    (accept),
        .pixel     (pixel_in),
        .window    (window),
        .win_valid (win_valid),
        .last_pix  (last_pix)
    );

    // Frame control FSM with registered busy/done; config latched at start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            busy        <= 1'b0;
            done_signal <= 1'b0;
        end else begin
            done_signal <= 1'b0;
            case (state)
                IDLE: if (start_signal) begin
                    state   <= RUN;
                    shift_q <= cfg_shift;
                    relu_q  <= cfg_relu;
                    busy    <= 1'b1;
                end
                RUN: if (accept && last_pix) begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
                DRAIN: if (drain_cnt == 3'(PIPE_LAT - 1)) begin
                    state       <= DONE;
                    busy        <= 1'b0;
                    done_signal <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Kernel registers: writable only while idle so a frame sees one kernel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++)
                coef[i] <= COEF_W'(SOBEL_X[i]);
        end else if (coef_we && (state == IDLE)) begin
            for (int i = 0; i < 9; i++)
                if (coef_addr == 4'(i))
                    coef[i] <= coef_data;
        end
    end

    // S1..S3: products, row sums, full-precision total, with valid tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++)
                prod[i] <= '0;
            for (int r = 0; r < 3; r++)
                row_sum[r] <= '0;
            total <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++)
                prod[i] <= PROD_W'($signed({1'b0, window[i*PIX_W +: PIX_W]}))
                         * PROD_W'(coef[i]);
            for (int r = 0; r < 3; r++)
                row_sum[r] <= ACC_W'(prod[r*3]) + ACC_W'(prod[r*3+1]) + ACC_W'(prod[r*3+2]);
            total <= row_sum[0] + row_sum[1] + row_sum[2];
            v1    <= win_valid;
            v2    <= v1;
            v3    <= v2;
        end
    end

    // S4 combinational part: arithmetic shift then optional ReLU.
    always_comb begin
        shifted  = total >>> shift_q;
        relu_val = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;
    end

    // S4 register: saturate into the output width; hold value between results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= v3;
            if (v3)
                result_out <= OUT_W'(sat_signed(64'(relu_val), OUT_W));
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: two instances (22-bit and 8-bit outputs)
// share stimulus; a frame-level arithmetic model fills expected queues.
module tb_conv2d_stream_engine;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NRES = (W - 2) * (H - 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              start_signal = 1'b0;
    logic [4:0]        cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic [7:0]        pixel_in = '0;
    logic              pixel_valid = 1'b0;

    logic signed [21:0] r22;
    logic               rv22, busy22, done22;
    logic signed [7:0]  r8;
    logic               rv8, busy8, done8;

    conv2d_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(8), .OUT_W(22)) dut (
        .clk(clk), .rst(rst), .start_signal(start_signal), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .result_out(r22), .result_valid(rv22), .busy(busy22), .done_signal(done22)
    );

    conv2d_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(8), .OUT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .start_signal(start_signal), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .result_out(r8), .result_valid(rv8), .busy(busy8), .done_signal(done8)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp8_q[$];
    int          kern [9];
    int          sobel [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    int          frame_pix [H][W];
    bit          quiet = 1'b0;
    int          quiet_hits = 0;
    int          n_res, n_res8, done_cnt, first_res_cyc, done_cyc;
    bit          sc_en = 1'b0;
    int          sc_addr, sc_val;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic longint sat_ref(input longint v, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: direct 3x3 valid convolution over the stored frame.
    task automatic build_expected(input int shift, input bit relu);
        longint acc;
        for (int y = 2; y < H; y++)
            for (int x = 2; x < W; x++) begin
                acc = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc += longint'(kern[r*3+c]) * longint'(frame_pix[y-2+r][x-2+c]);
                acc = acc >>> shift;
                if (relu && acc < 0) acc = 0;
                exp_q.push_back(64'(sat_ref(acc, 22)));
                exp8_q.push_back(64'(sat_ref(acc, 8)));
            end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rv22) begin
            if (quiet) quiet_hits++;
            else begin
                if (n_res == 0) first_res_cyc = int'(cyc);
                n_res++;
                if (exp_q.size() == 0) check_val("extra_result_w22", 64'(n_res), 64'd0);
                else check_val("result_w22", 64'(r22), exp_q.pop_front());
            end
        end
        if (rv8) begin
            if (quiet) quiet_hits++;
            else begin
                n_res8++;
                if (exp8_q.size() == 0) check_val("extra_result_w8", 64'(n_res8), 64'd0);
                else check_val("result_w8", 64'(r8), exp8_q.pop_front());
            end
        end
        if (done22) begin
            if (quiet) quiet_hits++;
            else begin
                done_cnt++;
                done_cyc = int'(cyc);
            end
        end
        if (done8 && quiet) quiet_hits++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = 8'(val);
        tick();
        coef_we = 1'b0;
        if (addr < 9) kern[addr] = val;
    endtask

    task automatic drive_noise();
        coef_we      = 1'($urandom_range(1));
        coef_addr    = 4'($urandom_range(15));
        coef_data    = 8'($urandom_range(255));
        start_signal = ($urandom_range(3) == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_result_out"}, 64'(r22), 64'd0);
        check_val({tag, "_result_valid"}, 64'(rv22), 64'd0);
        check_val({tag, "_busy"}, 64'(busy22), 64'd0);
        check_val({tag, "_done"}, 64'(done22), 64'd0);
        check_val({tag, "_result_out_w8"}, 64'(r8), 64'd0);
    endtask

    task automatic do_mid_reset();
        rst          = 1'b0;
        pixel_valid  = 1'b0;
        coef_we      = 1'b0;
        start_signal = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp8_q.delete();
        for (int i = 0; i < 9; i++) kern[i] = sobel[i];
        quiet      = 1'b1;
        quiet_hits = 0;
        repeat (30) tick();
        check_val("midrst_quiet", 64'(quiet_hits), 64'd0);
        quiet = 1'b0;
    endtask

    // mode: 0 p=8x, 1 p=y*8+x, 2 all 255, 3 random
    task automatic run_frame(input string name, input int mode, input int shift, input bit relu,
                             input int gap_pct, input bit noise, input int rst_y);
        int acc_cyc;
        int last_cyc;
        acc_cyc  = 0;
        last_cyc = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       frame_pix[y][x] = 8 * x;
                    1:       frame_pix[y][x] = y * 8 + x;
                    2:       frame_pix[y][x] = 255;
                    default: frame_pix[y][x] = int'($urandom_range(255));
                endcase
        if (sc_en) begin
            coef_we   = 1'b1;
            coef_addr = 4'(sc_addr);
            coef_data = 8'(sc_val);
            if (sc_addr < 9) kern[sc_addr] = sc_val;
        end
        exp_q.delete();
        exp8_q.delete();
        build_expected(shift, relu);
        n_res = 0; n_res8 = 0; done_cnt = 0; first_res_cyc = 0; done_cyc = 0;

        start_signal = 1'b1;
        cfg_shift    = 5'(shift);
        cfg_relu     = relu;
        tick();
        start_signal = 1'b0;
        coef_we      = 1'b0;
        sc_en        = 1'b0;
        check_val({name, "_busy_run"}, 64'(busy22), 64'd1);

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (y == rst_y && x == 0) begin
                    do_mid_reset();
                    return;
                end
                if (gap_pct > 0)
                    while (int'($urandom_range(99)) < gap_pct) begin
                        pixel_valid = 1'b0;
                        if (noise) drive_noise();
                        tick();
                    end
                pixel_valid = 1'b1;
                pixel_in    = 8'(frame_pix[y][x]);
                if (noise) drive_noise();
                tick();
                if (x == 2 && y == 2) acc_cyc = int'(cyc);
                if (x == W - 1 && y == H - 1) last_cyc = int'(cyc);
            end
        pixel_valid  = 1'b0;
        coef_we      = 1'b0;
        start_signal = 1'b0;

        for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
        repeat (3) tick();

        check_val({name, "_done_count"}, 64'(done_cnt), 64'd1);
        check_val({name, "_done_cycle"}, 64'(done_cyc), 64'(last_cyc + 4));
        check_val({name, "_first_latency"}, 64'(first_res_cyc), 64'(acc_cyc + 4));
        check_val({name, "_n_results"}, 64'(n_res), 64'(NRES));
        check_val({name, "_n_results_w8"}, 64'(n_res8), 64'(NRES));
        check_val({name, "_leftover"}, 64'(exp_q.size() + exp8_q.size()), 64'd0);
        check_val({name, "_busy_idle"}, 64'(busy22), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 9; i++) kern[i] = sobel[i];
        rst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        run_frame("sobel", 0, 0, 1'b0, 0, 1'b0, -1);
        run_frame("sobel_relu", 0, 0, 1'b1, 0, 1'b0, -1);

        // identity kernel; centre tap committed together with start
        for (int i = 0; i < 9; i++) if (i != 4) write_coef(i, 0);
        write_coef(12, 55);
        sc_en = 1'b1; sc_addr = 4; sc_val = 1;
        run_frame("ident", 1, 0, 1'b0, 0, 1'b0, -1);

        for (int i = 0; i < 9; i++) write_coef(i, 1);
        run_frame("sat_s0", 2, 0, 1'b0, 0, 1'b0, -1);
        run_frame("sat_s4", 2, 4, 1'b0, 0, 1'b0, -1);
        run_frame("sat_s5", 2, 5, 1'b0, 0, 1'b0, -1);

        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 1 : 0);
        run_frame("ident_gaps", 1, 0, 1'b0, 50, 1'b1, -1);

        for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(255)) - 128);
        run_frame("random", 3, int'($urandom_range(3)), 1'($urandom_range(1)), 30, 1'b0, -1);

        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 1 : 0);
        run_frame("ident_rst", 1, 0, 1'b0, 0, 1'b0, 4);
        run_frame("sobel_after_rst", 0, 0, 1'b0, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised successor of the fixed 32x32 Sobel convolution engine.
- Streams a raster-order image, one pixel per valid cycle, and computes a 3x3 "valid" convolution (no padding).
- The 3x3 coefficient set is runtime-loadable; a post-processing stage applies arithmetic shift, optional ReLU and signed saturation.
- Sits between the pixel source/DMA and the pooling/activation stage of the NPU datapath.

Parameters:
- IMG_W, 32, image width in pixels (>=3).
- IMG_H, 32, image height in lines (>=3).
- PIX_W, 8, unsigned pixel width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 22, signed result width after saturation.
- Derived localparam ACC_W = PIX_W+COEF_W+5. This is the signed full-precision sum of 9 products.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous active-low.
- start_signal  in  1  start one frame; sampled only in IDLE.
- cfg_shift  in  5  arithmetic right-shift amount; latched on accepted start.
- cfg_relu  in  1  1 = clamp negative results to 0; latched on accepted start.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient index 0..8 (row*3+col); 9..15 ignored.
- coef_data  in  COEF_W  signed coefficient value.
- pixel_in  in  PIX_W  pixel data.
- pixel_valid  in  1  pixel_in valid this cycle.
- result_out  out  OUT_W  signed convolution result.
- result_valid  out  1  result_out valid this cycle.
- busy  out  1  high in RUN and DRAIN.
- done_signal  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Clock, reset and polarity: one clock, clk; reset rst is synchronous, active-low. All state updates on posedge clk.
- Reset values:
  - result_out=0, result_valid=0, busy=0, done_signal=0.
  - State IDLE; counters, line buffers, window and pipeline cleared.
  - Coefficients load the default Sobel-X kernel {1,0,-1; 2,0,-2; 1,0,-1}.
  - cfg_shift=0, cfg_relu=0.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE -> RUN on start_signal; latches cfg_shift and cfg_relu.
  - RUN -> DRAIN on the accepted pixel at x=IMG_W-1, y=IMG_H-1.
  - DRAIN -> DONE when the pipeline is empty (4 cycles after the last pixel).
  - DONE -> IDLE unconditionally; done_signal is high only in DONE.
- Pixel acceptance: a pixel is accepted only when pixel_valid=1 in RUN. pixel_valid in IDLE, DRAIN or DONE is ignored.
- Gaps: bubbles in pixel_valid are allowed; the window and counters hold during gaps.
- Counters: cnt_x wraps IMG_W-1 -> 0 and increments cnt_y. Both clear on entry to RUN.
- Windowing: two line buffers of IMG_W entries plus a 3x3 window register. An accepted pixel at (x,y) with x>=2 and y>=2 produces the window whose bottom-right is (x,y). Each frame yields (IMG_W-2)*(IMG_H-2) results.
- Row boundary: windows never straddle rows; x<2 produces no result.
- Pipeline (fixed latency 4 cycles from the accepting edge to result_valid):
  - S1: 9 registered products (unsigned pixel zero-extended x signed coefficient).
  - S2: three registered row sums.
  - S3: registered total at ACC_W bits.
  - S4: post-process:
    - arithmetic right shift by the latched cfg_shift;
    - if cfg_relu=1, negative values become 0;
    - signed saturation to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Output hold: result_valid is a shifted copy of the window-valid flag. result_out holds its last value when result_valid=0.
- Coefficient writes:
  - Take effect only in IDLE; coef_we in any other state is ignored.
  - Kernel is stable for a whole frame.
  - Coefficients persist across frames until overwritten or reset.
- Simultaneous events:
  - start_signal together with coef_we in IDLE: the write commits and the frame starts; the new coefficient applies to this frame.
  - start_signal outside IDLE is ignored.
- Reset mid-frame: everything returns to reset values on the next edge. No result_valid or done_signal is produced afterwards.

Decomposition:
- Package conv_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - PIPE_LAT=4;
  - default Sobel-X kernel constant;
  - signed saturate function.
- Sub-module conv_window_gen: line buffers, counters, 3x3 window and window-valid flag, parametrised by IMG_W, IMG_H, PIX_W.
- MAC tree and post-processing stay in the top module.

Test Plan:
- Default kernel, 8x8 frame, p(x,y)=8x, cfg_shift=0, cfg_relu=0 -> 36 results, each -64. First result_valid 4 cycles after accepting (2,2). done_signal pulses once, 1 cycle after DRAIN completes.
- Same stimulus with cfg_relu=1 -> 36 results, all 0.
- Load identity kernel (coef 4=1, rest 0), 8x8 frame, p=y*8+x -> result k equals the centre pixel (x-1,y-1). First value 9, last 54.
- OUT_W=8, all coefficients 1, all pixels 255 -> raw 2295 saturates to 127. cfg_shift=4 -> 143 saturates to 127; cfg_shift=5 -> 71.
- Random pixel_valid gaps (~50% duty) on the 8x8 identity frame -> results identical to the gap-free run, still 36 results. coef_we during RUN has no effect.
- Assert rst=0 for one cycle mid-frame (y=4) -> no result_valid and no done_signal afterwards. Coefficients return to Sobel-X. A new start_signal processes a full frame correctly.
